i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver.sv | 173 +++++++++++++++++
 tb/tb_i2s_receiver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronises the codec's BCLK/LRCLK/SDATA into the
// system clock domain and delivers one left/right sample pair per frame.
module i2s_receiver #(
   parameter int DATA_WIDTH  = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_bclk,
   input  logic                  i_lrclk,
   input  logic                  i_sdata,
   output logic [DATA_WIDTH-1:0] o_data_left,
   output logic [DATA_WIDTH-1:0] o_data_right,
   output logic                  o_data_valid,
   output logic                  o_frame_error
);

   typedef enum logic [1:0] {
      WAIT_SYNC,
      LEFT,
      RIGHT
   } state_t;

   localparam logic [5:0] DW_C    = 6'(DATA_WIDTH);
   localparam logic [5:0] CNT_MAX = 6'd63;

   logic [SYNC_STAGES-1:0] bclk_sync_q;
   logic [SYNC_STAGES-1:0] lrclk_sync_q;
   logic [SYNC_STAGES-1:0] sdata_sync_q;
   logic                   bclk_prev_q;
   logic                   lrclk_prev_q;
   logic [5:0]             cnt_q;
   logic [5:0]             cnt_d;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic [DATA_WIDTH-1:0]  shift_d;
   logic [DATA_WIDTH-1:0]  hold_left_q;
   logic [DATA_WIDTH-1:0]  data_left_q;
   logic [DATA_WIDTH-1:0]  data_right_q;
   logic                   left_ok_q;
   logic                   valid_q;
   logic                   error_q;
   state_t                 state_q;

   logic bclk_s;
   logic lrclk_s;
   logic sdata_s;
   logic bit_evt;
   logic boundary;
   logic capture;
   logic short_slot;

   assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
   assign lrclk_s = lrclk_sync_q[SYNC_STAGES-1];
   assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

   assign bit_evt    = bclk_s & ~bclk_prev_q;
   assign boundary   = bit_evt & (lrclk_s != lrclk_prev_q);
   assign capture    = bit_evt & ~boundary & (cnt_d == DW_C);
   assign short_slot = cnt_q < DW_C;

   // Bring the three codec signals into i_clock domain; keep last BCLK for edges
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         bclk_sync_q  <= '0;
         lrclk_sync_q <= '0;
         sdata_sync_q <= '0;
         bclk_prev_q  <= 1'b0;
      end else begin
         bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
         lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], i_lrclk};
         sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i_sdata};
         bclk_prev_q  <= bclk_s;
      end
   end

   // Bit position within the slot; count 0 is the I2S delay bit
   always_comb begin
      cnt_d = cnt_q;
      if (bit_evt) begin
         if (boundary) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
         end else begin
            cnt_d = 6'(cnt_q + 6'd1);
         end
      end
   end

   // Data bits 1..DATA_WIDTH enter MSB first; delay and padding bits are dropped
   always_comb begin
      shift_d = shift_q;
      if (bit_evt && !boundary && cnt_d >= 6'd1 && cnt_d <= DW_C) begin
         shift_d = {shift_q[DATA_WIDTH-2:0], sdata_s};
      end
   end

   // Slot counter, shifter and the LRCLK value seen at the previous bit
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         cnt_q        <= '0;
         shift_q      <= '0;
         lrclk_prev_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         if (bit_evt) begin
            lrclk_prev_q <= lrclk_s;
         end
      end
   end

   // Slot sequencing, left holding register and registered output strobes
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= WAIT_SYNC;
         left_ok_q    <= 1'b0;
         hold_left_q  <= '0;
         data_left_q  <= '0;
         data_right_q <= '0;
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         if (bit_evt) begin
            unique case (state_q)
               WAIT_SYNC: begin
                  if (boundary && !lrclk_s) begin
                     state_q <= LEFT;
                  end
               end
               LEFT: begin
                  if (boundary) begin
                     if (short_slot) begin
                        error_q   <= 1'b1;
                        left_ok_q <= 1'b0;
                     end
                     state_q <= lrclk_s ? RIGHT : LEFT;
                  end else if (capture) begin
                     hold_left_q <= shift_d;
                     left_ok_q   <= 1'b1;
                  end
               end
               RIGHT: begin
                  if (boundary) begin
                     if (short_slot) begin
                        error_q   <= 1'b1;
                        left_ok_q <= 1'b0;
                     end
                     state_q <= lrclk_s ? RIGHT : LEFT;
                  end else if (capture && left_ok_q) begin
                     data_right_q <= shift_d;
                     data_left_q  <= hold_left_q;
                     valid_q      <= 1'b1;
                     left_ok_q    <= 1'b0;
                  end
               end
               default: begin
                  state_q   <= WAIT_SYNC;
                  left_ok_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_data_left   = data_left_q;
   assign o_data_right  = data_right_q;
   assign o_data_valid  = valid_q;
   assign o_frame_error = error_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: an I2S codec model drives frames, a scoreboard
// holds the expected sample pairs and a monitor checks each valid strobe.
module tb_i2s_receiver;

   localparam int DW = 24;
   localparam int SS = 2;

   typedef struct packed {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } exp_t;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          bclk  = 1'b0;
   logic          lrclk = 1'b0;
   logic          sdata = 1'b0;
   logic [DW-1:0] dl;
   logic [DW-1:0] dr;
   logic          dv;
   logic          fe;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   vcnt     = 0;
   int   ecnt     = 0;
   int   edge_cnt = 0;
   int   lsb_edge = 0;
   logic [DW-1:0] last_l = '0;
   logic [DW-1:0] last_r = '0;

   i2s_receiver #(
      .DATA_WIDTH (DW),
      .SYNC_STAGES(SS)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_bclk       (bclk),
      .i_lrclk      (lrclk),
      .i_sdata      (sdata),
      .o_data_left  (dl),
      .o_data_right (dr),
      .o_data_valid (dv),
      .o_frame_error(fe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic monitor();
      exp_t e;
      logic dv_d;
      logic fe_d;
      int   lat;
      dv_d = 1'b0;
      fe_d = 1'b0;
      forever begin
         @(negedge clk);
         if (dv) begin
            vcnt++;
            checks++;
            if (dv_d) begin
               errors++;
               $display("FAIL valid_width: high %0d cycles, want 1", 2);
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got L=%h R=%h, want none",
                        dl, dr);
            end else begin
               e = sb.pop_front();
               lat = edge_cnt - lsb_edge;
               checks += 3;
               if (dl !== e.l) begin
                  errors++;
                  $display("FAIL sb_left: got %h want %h", dl, e.l);
               end
               if (dr !== e.r) begin
                  errors++;
                  $display("FAIL sb_right: got %h want %h", dr, e.r);
               end
               if (lat !== SS + 1) begin
                  errors++;
                  $display("FAIL latency: got %0d edges want %0d",
                           lat, SS + 1);
               end
               last_l = e.l;
               last_r = e.r;
            end
         end
         if (fe) begin
            ecnt++;
            checks++;
            if (fe_d) begin
               errors++;
               $display("FAIL error_width: high 2+ cycles, want 1");
            end
         end
         dv_d = dv;
         fe_d = fe;
      end
   endtask

   // One BCLK period: data changes on the falling edge, DUT samples on rise
   task automatic send_bit(input logic lr, input logic d, input logic mark);
      bclk  = 1'b0;
      lrclk = lr;
      sdata = d;
      #40;
      bclk = 1'b1;
      if (mark) lsb_edge = edge_cnt;
      #40;
   endtask

   // Bit 0 is the I2S delay bit, bits 1..DW carry the word, the rest is pad
   task automatic send_slot(input logic lr, input logic [DW-1:0] w,
                            input int len);
      logic d;
      for (int b = 0; b < len; b++) begin
         if (b >= 1 && b <= DW) d = w[DW-b];
         else d = 1'($urandom_range(0, 1));
         send_bit(lr, d, lr && (b == DW));
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input int len, input logic expect_valid);
      exp_t e;
      send_slot(1'b0, l, len);
      if (expect_valid) begin
         e.l = l;
         e.r = r;
         sb.push_back(e);
      end
      send_slot(1'b1, r, len);
   endtask

   task automatic check_outputs_zero(input string tag);
      checks += 4;
      if (dl !== '0) begin
         errors++;
         $display("FAIL %s_left: got %h want 0", tag, dl);
      end
      if (dr !== '0) begin
         errors++;
         $display("FAIL %s_right: got %h want 0", tag, dr);
      end
      if (dv !== 1'b0) begin
         errors++;
         $display("FAIL %s_valid: got %b want 0", tag, dv);
      end
      if (fe !== 1'b0) begin
         errors++;
         $display("FAIL %s_ferr: got %b want 0", tag, fe);
      end
   endtask

   task automatic check_counts(input string tag, input int dv_got,
                               input int dv_exp, input int fe_got,
                               input int fe_exp);
      checks += 2;
      if (dv_got !== dv_exp) begin
         errors++;
         $display("FAIL %s_valids: got %0d want %0d", tag, dv_got, dv_exp);
      end
      if (fe_got !== fe_exp) begin
         errors++;
         $display("FAIL %s_ferrs: got %0d want %0d", tag, fe_got, fe_exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #100;
      check_outputs_zero("reset");
      rst = 1'b0;
      #100;
      check_outputs_zero("post_reset");
   endtask

   task automatic test_standard();
      int v0 = vcnt;
      int e0 = ecnt;
      send_slot(1'b1, '0, 32);
      send_frame(24'h123456, 24'hFEDCBA, 32, 1'b1);
      #200;
      check_counts("standard", vcnt - v0, 1, ecnt - e0, 0);
      checks += 2;
      if (dl !== 24'h123456) begin
         errors++;
         $display("FAIL standard_left: got %h want 123456", dl);
      end
      if (dr !== 24'hFEDCBA) begin
         errors++;
         $display("FAIL standard_right: got %h want fedcba", dr);
      end
   endtask

   task automatic test_latency();
      int v0 = vcnt;
      int e0 = ecnt;
      for (int i = 0; i < 100; i++) begin
         send_frame(DW'($urandom), DW'($urandom), 32, 1'b1);
      end
      #200;
      check_counts("back_to_back", vcnt - v0, 100, ecnt - e0, 0);
   endtask

   task automatic test_startup_mid_right();
      int v0;
      rst = 1'b1;
      send_slot(1'b0, 24'h111111, 32);
      for (int b = 0; b < 32; b++) begin
         if (b == 10) rst = 1'b0;
         send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end
      last_l = '0;
      last_r = '0;
      v0 = vcnt;
      check_outputs_zero("startup_idle");
      send_frame(24'h2468AC, 24'h13579B, 32, 1'b1);
      #200;
      check_counts("startup", vcnt - v0, 1, 0, 0);
   endtask

   task automatic test_short_slot();
      int v0 = vcnt;
      int e0 = ecnt;
      send_slot(1'b0, 24'hABCDEF, 11);
      send_slot(1'b1, 24'h654321, 32);
      checks += 2;
      if (dl !== last_l) begin
         errors++;
         $display("FAIL short_hold_left: got %h want %h", dl, last_l);
      end
      if (dr !== last_r) begin
         errors++;
         $display("FAIL short_hold_right: got %h want %h", dr, last_r);
      end
      send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 1'b1);
      #200;
      check_counts("short", vcnt - v0, 1, ecnt - e0, 1);
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 1'b1);
      send_slot(1'b0, 24'h777777, 32);
      for (int b = 0; b < 12; b++) send_bit(1'b1, 1'b1, 1'b0);
      bclk  = 1'b0;
      lrclk = 1'b1;
      sdata = 1'b1;
      #20;
      rst = 1'b1;
      #1;
      check_outputs_zero("reset_async");
      #19;
      bclk = 1'b1;
      #40;
      for (int b = 13; b < 16; b++) send_bit(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      for (int b = 16; b < 32; b++) send_bit(1'b1, 1'b1, 1'b0);
      last_l = '0;
      last_r = '0;
      v0 = vcnt;
      send_frame(24'hC3C3C3, 24'h3C3C3C, 32, 1'b1);
      #200;
      check_counts("reset_mid", vcnt - v0, 1, 0, 0);
   endtask

   // 25-bit slots: delay bit plus a full word, no padding at all
   task automatic test_extremes();
      int v0 = vcnt;
      int e0 = ecnt;
      send_frame(24'h800000, 24'h7FFFFF, 25, 1'b1);
      send_slot(1'b0, 24'h000001, 6);
      send_slot(1'b1, 24'h000002, 25);
      #200;
      checks += 2;
      if (dl !== 24'h800000) begin
         errors++;
         $display("FAIL extreme_left: got %h want 800000", dl);
      end
      if (dr !== 24'h7FFFFF) begin
         errors++;
         $display("FAIL extreme_right: got %h want 7fffff", dr);
      end
      send_frame(24'h7FFFFF, 24'h800000, 25, 1'b1);
      #200;
      check_counts("extremes", vcnt - v0, 2, ecnt - e0, 1);
   endtask

   initial begin
      #2;
      fork
         monitor();
      join_none
      test_reset();
      test_standard();
      test_latency();
      test_startup_mid_right();
      test_short_slot();
      test_reset_mid_frame();
      test_extremes();
      #200;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
